mem_arbiter_n: RTL and testbench

Parametrised, registered round-robin arbiter sharing one RAM port among NCORES cores, each with one instruction and one data source (2·NCORES sources). It sits between the per-core cache blocks and the RAM interface of the multicore top. It also aggregates per-core `flushed` flags into a system `halt`. It generalises the fixed two-core top-level wiring to N cores, with fair arbitration and sticky halt tracking.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_n_rr_picker.sv | 26 ++
 rtl/mem_arbiter_n.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter_n.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-core round-robin RAM arbiter.
// The optional stall timeout is enabled with the ARB_TIMEOUT_EN macro.
package mem_arb_pkg;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t IDLE  = 1'b0;
    localparam arb_state_t GRANT = 1'b1;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Width of a source index: two sources (data, instruction) per core.
    function automatic int unsigned src_w(input int unsigned ncores);
        return (ncores < 1) ? 1 : $clog2(2 * ncores);
    endfunction

endpackage

// File: rtl/mem_arbiter_n_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
    parameter int unsigned NSRC = 4,
    parameter int unsigned SW   = 2
) (
    input  logic [NSRC-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic            valid,
    output logic [SW-1:0]   idx
);

    int cand;

    always_comb begin
        valid = |req;
        idx   = '0;
        cand  = 0;
        // Walk offsets from far to near so the closest requester wins last.
        for (int off = int'(NSRC) - 1; off >= 0; off--) begin
            cand = int'(ptr) + off;
            if (cand >= int'(NSRC)) cand = cand - int'(NSRC);
            if (req[cand]) idx = SW'(cand);
        end
    end

endmodule

// File: rtl/mem_arbiter_n.sv
// Registered round-robin arbiter sharing one RAM port among 2*NCORES sources, plus halt tracking.
// Define ARB_TIMEOUT_EN to add the GRANT stall timeout and sticky err flag.
module mem_arbiter_n
    import mem_arb_pkg::*;
#(
    parameter int unsigned NCORES  = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 64
`endif
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NCORES-1:0]    iREN,
    input  logic [NCORES*AW-1:0] iaddr,
    input  logic [NCORES-1:0]    dREN,
    input  logic [NCORES-1:0]    dWEN,
    input  logic [NCORES*AW-1:0] daddr,
    input  logic [NCORES*DW-1:0] dstore,
    output logic [NCORES-1:0]    iwait,
    output logic [NCORES-1:0]    dwait,
    output logic [NCORES*DW-1:0] iload,
    output logic [NCORES*DW-1:0] dload,
    output logic [AW-1:0]        ramaddr,
    output logic [DW-1:0]        ramstore,
    output logic                 ramREN,
    output logic                 ramWEN,
    input  logic [DW-1:0]        ramload,
    input  logic [1:0]           ramstate,
    input  logic [NCORES-1:0]    flushed,
    output logic                 halt,
    output logic                 err
);

    localparam int unsigned NSRC = 2 * NCORES;
    localparam int unsigned SW   = src_w(NCORES);

    arb_state_t        state_q, state_d;
    logic [SW-1:0]     gnt_q, gnt_d, rr_q, rr_d, gnt_nxt, pick_idx;
    logic              pick_valid;
    logic [NSRC-1:0]   req;
    logic [NCORES-1:0] flushed_q;
    logic              halt_q;
    logic              is_access;
    logic              timeout;
    int                gc;

    always_comb begin
        req = '0;
        for (int c = 0; c < int'(NCORES); c++) begin
            req[2*c]   = dREN[c] | dWEN[c];
            req[2*c+1] = iREN[c];
        end
    end

    rr_picker #(
        .NSRC(NSRC),
        .SW  (SW)
    ) u_picker (
        .req  (req),
        .ptr  (rr_q),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    assign gnt_nxt   = (gnt_q == SW'(NSRC - 1)) ? '0 : gnt_q + SW'(1);
    assign is_access = (ramstate_t'(ramstate) == ACCESS);

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    assign timeout = (state_q == GRANT) && (cnt_q == CW'(TIMEOUT - 1));

    // Counter only runs while a grant is outstanding; saturates at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) cnt_d = '0;
        else if (cnt_q != CW'(TIMEOUT - 1)) cnt_d = cnt_q + CW'(1);
        err_d = err_q | (timeout & req[gnt_q] & ~is_access);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_d     = rr_q;
        ramaddr  = '0;
        ramstore = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        gc       = int'(gnt_q >> 1);
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[gnt_q]) begin
                    // Requester withdrew: drop strobes, keep the pointer.
                    state_d = IDLE;
                end else begin
                    if (!gnt_q[0]) begin
                        ramaddr  = daddr[gc*AW +: AW];
                        ramstore = dstore[gc*DW +: DW];
                        ramWEN   = dWEN[gc];
                        ramREN   = dREN[gc] & ~dWEN[gc];
                    end else begin
                        ramaddr = iaddr[gc*AW +: AW];
                        ramREN  = 1'b1;
                    end
                    if (is_access || timeout) begin
                        if (gnt_q[0]) begin
                            iwait[gc] = 1'b0;
                            if (is_access) iload[gc*DW +: DW] = ramload;
                        end else begin
                            dwait[gc] = 1'b0;
                            if (is_access) dload[gc*DW +: DW] = ramload;
                        end
                        state_d = IDLE;
                        rr_d    = gnt_nxt;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            rr_q      <= '0;
            flushed_q <= '0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            flushed_q <= flushed_q | flushed;
            halt_q    <= &flushed_q;
        end
    end

    assign halt = halt_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed self-checking bench for mem_arbiter_n with NCORES=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_arbiter_n;

    logic        CLK;
    logic        nRST;
    logic [1:0]  iREN, dREN, dWEN, iwait, dwait, flushed;
    logic [63:0] iaddr, daddr, dstore, iload, dload;
    logic [31:0] ramaddr, ramstore, ramload;
    logic        ramREN, ramWEN, halt, err;
    logic [1:0]  ramstate;

    int total;
    int bad;

    logic [31:0] exp_addr [5];
    logic [1:0]  exp_dw, exp_iw;
    int          src;

    mem_arbiter_n #(
        .NCORES (2),
        .AW     (32),
        .DW     (32)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT(8)
`endif
    ) u_dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .iwait   (iwait),
        .dwait   (dwait),
        .iload   (iload),
        .dload   (dload),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramload (ramload),
        .ramstate(ramstate),
        .flushed (flushed),
        .halt    (halt),
        .err     (err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        nRST     = 1'b0;
        iREN     = 2'b11;
        dREN     = 2'b00;
        dWEN     = 2'b00;
        iaddr    = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = 2'd0;
        flushed  = 2'b00;

        // Reset state with requests pending
        smp();
        check("rst_strobes", {ramREN, ramWEN}, 2'b00);
        check("rst_waits", {iwait, dwait}, 4'b1111);
        check("rst_loads", {iload, dload} == '0, 1'b1);
        check("rst_halt_err", {halt, err}, 2'b00);

        tick(); nRST = 1'b1; iREN = 2'b00;
        smp();

        // Single instruction request from core 0 (source 1)
        tick(); iREN = 2'b01; iaddr = 64'h0;
        smp();
        check("single_idle_ren", ramREN, 1'b0);
        check("single_idle_wait", iwait, 2'b11);
        tick();
        smp();
        check("single_g1_ren", {ramREN, ramWEN}, 2'b10);
        check("single_g1_addr", ramaddr, 32'h0);
        check("single_g1_wait", iwait, 2'b11);
        check("single_g1_load", iload, 64'h0);
        tick(); ramstate = 2'd2; ramload = 32'hCAFE0001;
        smp();
        check("single_acc_ren", ramREN, 1'b1);
        check("single_acc_wait", {iwait, dwait}, 4'b1011);
        check("single_acc_load", iload, 64'h0000_0000_CAFE_0001);
        tick(); iREN = 2'b00; ramstate = 2'd0;
        smp();
        check("single_after", {ramREN, iwait, iload == 64'h0}, 4'b0111);

        // Reset asserted while a grant is outstanding drops it at once
        tick(); dREN = 2'b10; daddr = 64'h0000_0080_0000_0000;
        smp();
        tick();
        smp();
        check("rstg_pre_addr", ramaddr, 32'h80);
        #1 nRST = 1'b0;
        #1;
        check("rstg_strobes", {ramREN, ramWEN, dwait}, 4'b0011);
        tick(); nRST = 1'b1; dREN = 2'b00;
        smp();

        // Round robin: all four sources, ACCESS on every GRANT cycle
        exp_addr[0] = 32'h100; exp_addr[1] = 32'h1000;
        exp_addr[2] = 32'h110; exp_addr[3] = 32'h1010;
        exp_addr[4] = 32'h100;
        tick();
        dREN = 2'b11; iREN = 2'b11;
        daddr = {32'h110, 32'h100}; iaddr = {32'h1010, 32'h1000};
        ramstate = 2'd2;
        smp();
        check("rr_first_idle", ramREN, 1'b0);
        for (int k = 0; k < 5; k++) begin
            src    = k % 4;
            exp_dw = (src % 2 == 0) ? ~(2'b01 << (src / 2)) : 2'b11;
            exp_iw = (src % 2 == 1) ? ~(2'b01 << (src / 2)) : 2'b11;
            tick();
            smp();
            check($sformatf("rr_addr%0d", k), ramaddr, exp_addr[k]);
            check($sformatf("rr_wait%0d", k), {iwait, dwait}, {exp_iw, exp_dw});
            tick();
            smp();
            check($sformatf("rr_gap%0d", k), ramREN, 1'b0);
        end
        // Source 1 is now granted; dropping everything aborts it
        tick(); dREN = 2'b00; iREN = 2'b00; ramstate = 2'd0;
        smp();
        check("rr_drop", {ramREN, ramWEN}, 2'b00);
        tick();
        smp();

        // Write wins over read on the same data port (source 2)
        tick(); dREN = 2'b10; dWEN = 2'b10;
        daddr = 64'h0000_0200_0000_0000; dstore = 64'hDEAD_BEEF_0000_0000;
        smp();
        tick();
        smp();
        check("wr_strobes", {ramWEN, ramREN}, 2'b10);
        check("wr_store", ramstore, 32'hDEADBEEF);
        check("wr_addr", ramaddr, 32'h200);
        tick(); ramstate = 2'd2;
        smp();
        check("wr_wait", dwait, 2'b01);
        tick(); dREN = 2'b00; dWEN = 2'b00; ramstate = 2'd0;
        smp();

        // Abort of source 3 must leave rr_ptr at 3
        tick(); iREN = 2'b10; iaddr = 64'h0000_3000_0000_0000;
        smp();
        tick();
        smp();
        check("ab_grant_addr", ramaddr, 32'h3000);
        tick(); iREN = 2'b00;
        smp();
        check("ab_strobes", {ramREN, ramWEN}, 2'b00);
        check("ab_waits", {iwait, dwait}, 4'b1111);
        tick(); iREN = 2'b10; dREN = 2'b01; daddr = 64'h40;
        smp();
        check("ab_idle", ramREN, 1'b0);
        tick();
        smp();
        check("ab_ptr_kept", ramaddr, 32'h3000);
        tick(); ramstate = 2'd2;
        smp();
        check("ab_acc_wait", iwait, 2'b01);
        tick(); iREN = 2'b00; ramstate = 2'd0;
        smp();
        tick();
        smp();
        check("ab_next_addr", ramaddr, 32'h40);
        tick(); ramstate = 2'd2; ramload = 32'h55;
        smp();
        check("ab_next_load", {dwait, dload}, {2'b10, 64'h55});
        tick(); dREN = 2'b00; ramstate = 2'd0;
        smp();

        // Halt: flushed[0] pulses in cycle 5, flushed[1] high from cycle 9.
        // flushed_q[1] latches at the edge ending cycle 9, halt at the next edge.
        for (int cyc = 0; cyc <= 20; cyc++) begin
            tick();
            flushed[0] = (cyc == 5);
            flushed[1] = (cyc >= 9);
            smp();
            check($sformatf("halt_c%0d", cyc), halt, (cyc >= 11));
        end
        #1 nRST = 1'b0;
        #1;
        check("halt_rst", halt, 1'b0);
        check("err_clear", err, 1'b0);
        tick(); nRST = 1'b1; flushed = 2'b00;
        smp();
        check("halt_after_rst", halt, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // RAM stuck BUSY: the 8th GRANT cycle completes with load 0 and sets err
        tick(); iREN = 2'b01; iaddr = 64'h0; ramstate = 2'd1; ramload = 32'h77;
        smp();
        for (int g = 1; g <= 8; g++) begin
            tick();
            smp();
            check($sformatf("to_wait%0d", g), iwait[0], (g != 8));
            if (g == 8) check("to_load", iload, 64'h0);
        end
        tick(); iREN = 2'b00; dREN = 2'b10; daddr = 64'h0000_0300_0000_0000;
        smp();
        check("to_err", err, 1'b1);
        tick();
        smp();
        check("to_next_addr", ramaddr, 32'h300);
        check("to_err_sticky", err, 1'b1);
        tick(); dREN = 2'b00; ramstate = 2'd0;
        smp();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
